road_background_scroller: RTL and testbench



---
 rtl/road_background_scroller_pkg.sv | 24 ++
 rtl/road_curve_ctrl.sv | 89 ++++++++
 rtl/road_background_scroller.sv | 133 +++++++++++++
 tb/tb_road_background_scroller.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/road_background_scroller_pkg.sv
// Shared constants for the road background scroller: palette, curve states, LFSR.
package road_background_scroller_pkg;

    // 3-bit RGB palette
    localparam logic [2:0] NEGRO    = 3'b000;
    localparam logic [2:0] ROJO     = 3'b100;
    localparam logic [2:0] VERDE    = 3'b010;
    localparam logic [2:0] AMARILLO = 3'b110;
    localparam logic [2:0] BLANCO   = 3'b111;

    // Curve FSM encoding
    localparam logic [1:0] STRAIGHT = 2'd0;
    localparam logic [1:0] DRIFT_L  = 2'd1;
    localparam logic [1:0] DRIFT_R  = 2'd2;
    localparam logic [1:0] HOLD     = 2'd3;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    // x^8+x^6+x^5+x^4+1, shifting left with the feedback entering bit 0
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

endpackage

// File: rtl/road_curve_ctrl.sv
// Curve sequencer: moves the road left edge through straight / drift / hold
// segments, one step per frame tick while the road is moving.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   STRAIGHT | road fixed; count a segment, then pick a drift direction
//   DRIFT_L  | road_left steps down by 1 per frame until MIN_LEFT
//   DRIFT_R  | road_left steps up by 1 per frame until MAX_LEFT
//   HOLD     | road fixed at the limit for one segment, then STRAIGHT
module road_curve_ctrl
    import road_background_scroller_pkg::*;
#(
    parameter int ROAD_LEFT_INIT = 192,
    parameter int MIN_LEFT       = 96,
    parameter int MAX_LEFT       = 320,
    parameter int SEGMENT_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       moving,
    output logic [9:0] road_left
);

    localparam int SEG_W = (SEGMENT_FRAMES > 1) ? $clog2(SEGMENT_FRAMES) : 1;
    localparam logic [SEG_W-1:0] SEG_LAST  = SEG_W'(SEGMENT_FRAMES - 1);
    localparam logic [9:0]       LEFT_INIT = 10'(ROAD_LEFT_INIT);
    localparam logic [9:0]       LEFT_MIN  = 10'(MIN_LEFT);
    localparam logic [9:0]       LEFT_MAX  = 10'(MAX_LEFT);

    logic [1:0]       state;
    logic [SEG_W-1:0] seg_cnt;
    logic [7:0]       lfsr;
    logic [7:0]       lfsr_nxt;

    assign lfsr_nxt = lfsr_next(lfsr);

    // Frame-rate FSM; everything freezes when the road is not moving
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= STRAIGHT;
            seg_cnt   <= '0;
            lfsr      <= LFSR_SEED;
            road_left <= LEFT_INIT;
        end else if (tick && moving) begin
            case (state)
                STRAIGHT: begin
                    if (seg_cnt == SEG_LAST) begin
                        seg_cnt <= '0;
                        lfsr    <= lfsr_nxt;
                        state   <= lfsr_nxt[0] ? DRIFT_L : DRIFT_R;
                    end else begin
                        seg_cnt <= seg_cnt + SEG_W'(1);
                    end
                end
                DRIFT_L: begin
                    // clamp covers entering the drift already at the limit
                    if (road_left <= LEFT_MIN + 10'd1) begin
                        road_left <= LEFT_MIN;
                        state     <= HOLD;
                    end else begin
                        road_left <= road_left - 10'd1;
                    end
                end
                DRIFT_R: begin
                    if (road_left >= LEFT_MAX - 10'd1) begin
                        road_left <= LEFT_MAX;
                        state     <= HOLD;
                    end else begin
                        road_left <= road_left + 10'd1;
                    end
                end
                HOLD: begin
                    if (seg_cnt == SEG_LAST) begin
                        seg_cnt <= '0;
                        state   <= STRAIGHT;
                    end else begin
                        seg_cnt <= seg_cnt + SEG_W'(1);
                    end
                end
                default: begin
                    state   <= STRAIGHT;
                    seg_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/road_background_scroller.sv
// Multi-lane road background: edge lines, scrolling dashed dividers, terrain
// and a death flash, with the road position driven by the curve sequencer.
module road_background_scroller
    import road_background_scroller_pkg::*;
#(
    parameter int NUM_LANES      = 2,
    parameter int LANE_W         = 64,
    parameter int EDGE_W         = 8,
    parameter int MARK_W         = 8,
    parameter int MARK_PERIOD    = 64,
    parameter int MARK_DASH      = 42,
    parameter int SPEED_W        = 4,
    parameter int FRAC_BITS      = 2,
    parameter int ROAD_LEFT_INIT = 192,
    parameter int MIN_LEFT       = 96,
    parameter int MAX_LEFT       = 320,
    parameter int SEGMENT_FRAMES = 120,
    parameter int FLASH_FRAMES   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               update_signal,
    input  logic [9:0]         pixel_x,
    input  logic [9:0]         pixel_y,
    input  logic               alive,
    input  logic [SPEED_W-1:0] speed,
    output logic [2:0]         rgb,
    output logic               on_road,
    output logic [9:0]         road_left
);

    localparam int PH_W  = $clog2(MARK_PERIOD);
    localparam int ACC_W = PH_W + FRAC_BITS;
    localparam int FL_W  = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [FL_W-1:0] FLASH_LAST = FL_W'(FLASH_FRAMES - 1);
    localparam logic [9:0]      ROAD_W     = 10'(NUM_LANES * LANE_W);
    localparam logic [9:0]      EDGE_R     = 10'(NUM_LANES * LANE_W - EDGE_W);
    localparam logic [9:0]      EDGE_L     = 10'(EDGE_W);
    localparam logic [PH_W:0]   DASH_LIM   = (PH_W + 1)'(MARK_DASH);

    logic [ACC_W-1:0] scroll_acc;
    logic [9:0]       scroll_int;
    logic [FL_W-1:0]  flash_cnt;
    logic             flash_phase;

    road_curve_ctrl #(
        .ROAD_LEFT_INIT (ROAD_LEFT_INIT),
        .MIN_LEFT       (MIN_LEFT),
        .MAX_LEFT       (MAX_LEFT),
        .SEGMENT_FRAMES (SEGMENT_FRAMES)
    ) u_curve (
        .clk       (clk),
        .reset     (reset),
        .tick      (update_signal),
        .moving    (speed != '0),
        .road_left (road_left)
    );

    assign scroll_int = 10'(scroll_acc >> FRAC_BITS);

    // Fixed-point scroll position, wraps once per dash period
    always_ff @(posedge clk) begin
        if (reset) begin
            scroll_acc <= '0;
        end else if (update_signal) begin
            scroll_acc <= scroll_acc + ACC_W'(speed);
        end
    end

    // Death flash: terrain alternates red/black every FLASH_FRAMES frames
    always_ff @(posedge clk) begin
        if (reset || alive) begin
            flash_cnt   <= '0;
            flash_phase <= 1'b0;
        end else if (update_signal) begin
            if (flash_cnt == FLASH_LAST) begin
                flash_cnt   <= '0;
                flash_phase <= ~flash_phase;
            end else begin
                flash_cnt <= flash_cnt + FL_W'(1);
            end
        end
    end

    logic [9:0]      rx;
    int              rx_i;
    logic [PH_W-1:0] dash_phase;
    logic            on_div;
    logic [2:0]      terrain;
    logic [2:0]      rgb_nxt;
    logic            on_road_nxt;

    // Pixel classifier, using the pre-update frame state
    always_comb begin
        rx          = pixel_x - road_left;
        rx_i        = int'(rx);
        dash_phase  = PH_W'(pixel_y - scroll_int);
        terrain     = alive ? VERDE : (flash_phase ? NEGRO : ROJO);
        on_div      = 1'b0;
        rgb_nxt     = terrain;
        on_road_nxt = 1'b0;
        for (int k = 1; k < NUM_LANES; k++) begin
            if ((rx_i > k * LANE_W - MARK_W / 2) && (rx_i < k * LANE_W + MARK_W / 2)) begin
                on_div = 1'b1;
            end
        end
        if (pixel_x < road_left || rx >= ROAD_W) begin
            rgb_nxt     = terrain;
            on_road_nxt = 1'b0;
        end else if (rx < EDGE_L || rx >= EDGE_R) begin
            rgb_nxt     = BLANCO;
            on_road_nxt = 1'b1;
        end else if (on_div) begin
            rgb_nxt     = ({1'b0, dash_phase} <= DASH_LIM) ? AMARILLO : NEGRO;
            on_road_nxt = 1'b1;
        end else begin
            rgb_nxt     = NEGRO;
            on_road_nxt = 1'b1;
        end
    end

    // One-cycle pixel pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb     <= 3'b000;
            on_road <= 1'b0;
        end else begin
            rgb     <= rgb_nxt;
            on_road <= on_road_nxt;
        end
    end

endmodule

// File: tb/tb_road_background_scroller.sv
// Scoreboard bench for road_background_scroller: a frame-level reference model
// predicts each pixel and road position; a monitor compares one cycle later.
module tb_road_background_scroller;

    localparam logic [2:0] C_NEGRO    = 3'b000;
    localparam logic [2:0] C_ROJO     = 3'b100;
    localparam logic [2:0] C_VERDE    = 3'b010;
    localparam logic [2:0] C_AMARILLO = 3'b110;
    localparam logic [2:0] C_BLANCO   = 3'b111;

    localparam int M_STR = 0, M_LEFT = 1, M_RIGHT = 2, M_HOLD = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       update_signal;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       alive;
    logic [3:0] speed;
    logic [2:0] rgb;
    logic       on_road;
    logic [9:0] road_left;

    always #5 clk = ~clk;

    road_background_scroller dut (
        .clk           (clk),
        .reset         (reset),
        .update_signal (update_signal),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .alive         (alive),
        .speed         (speed),
        .rgb           (rgb),
        .on_road       (on_road),
        .road_left     (road_left)
    );

    typedef struct {
        int         due;
        bit         is_mark;
        bit         reached;
        logic [2:0] rgb;
        logic       onr;
        logic [9:0] rl;
        string      tag;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   end_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model (frame level) ----------------
    int         m_acc, m_rl, m_mode, m_seg, m_fcnt;
    bit         m_phase;
    logic [7:0] m_lfsr;

    function automatic void model_reset();
        m_acc = 0; m_rl = 192; m_mode = M_STR; m_seg = 0;
        m_fcnt = 0; m_phase = 0; m_lfsr = 8'hA5;
    endfunction

    function automatic void classify(input int px, input int py, input bit alv,
                                     output logic [2:0] c, output logic onr);
        int rx, ph, d;
        bit div;
        rx = px - m_rl;
        div = 0;
        if (rx < 0 || rx >= 128) begin
            onr = 0;
            c = alv ? C_VERDE : (m_phase ? C_NEGRO : C_ROJO);
            return;
        end
        onr = 1;
        if (rx < 8 || rx >= 120) begin
            c = C_BLANCO;
            return;
        end
        for (int k = 1; k < 2; k++) begin
            d = rx - k * 64;
            if (d < 0) d = -d;
            if (d < 4) div = 1;
        end
        ph = (((py - m_acc / 4) % 1024) + 1024) % 1024 % 64;
        c = (div && ph <= 42) ? C_AMARILLO : C_NEGRO;
    endfunction

    function automatic void model_frame(input bit tk, input int spd, input bit alv);
        logic [7:0] l;
        if (alv) begin
            m_fcnt = 0; m_phase = 0;
        end else if (tk) begin
            m_fcnt++;
            if (m_fcnt == 8) begin m_fcnt = 0; m_phase = !m_phase; end
        end
        if (!tk) return;
        m_acc = (m_acc + spd) % 256;
        if (spd == 0) return;
        case (m_mode)
            M_STR: begin
                m_seg++;
                if (m_seg == 120) begin
                    m_seg = 0;
                    l = m_lfsr;
                    m_lfsr = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
                    m_mode = m_lfsr[0] ? M_LEFT : M_RIGHT;
                end
            end
            M_LEFT: begin
                m_rl--;
                if (m_rl <= 96) begin m_rl = 96; m_mode = M_HOLD; end
            end
            M_RIGHT: begin
                m_rl++;
                if (m_rl >= 320) begin m_rl = 320; m_mode = M_HOLD; end
            end
            default: begin
                m_seg++;
                if (m_seg == 120) begin m_seg = 0; m_mode = M_STR; end
            end
        endcase
    endfunction

    // ---------------- stimulus ----------------
    function automatic int rnd_x();
        return int'($urandom_range(100, 460));
    endfunction

    function automatic int rnd_y();
        return int'($urandom_range(0, 479));
    endfunction

    task automatic drive(input bit tk, input int px, input int py, input string tag);
        exp_t e;
        logic [2:0] c;
        logic o;
        update_signal = tk;
        pixel_x = 10'(px);
        pixel_y = 10'(py);
        classify(px, py, alive, c, o);
        model_frame(tk, int'(speed), alive);
        e.due = cyc + 1; e.is_mark = 0; e.reached = 1;
        e.rgb = c; e.onr = o; e.rl = 10'(m_rl); e.tag = tag;
        sbq.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input bit tk);
        exp_t e;
        reset = 1'b1;
        update_signal = tk;
        model_reset();
        e.due = cyc + 1; e.is_mark = 0; e.reached = 1;
        e.rgb = 3'b000; e.onr = 1'b0; e.rl = 10'd192; e.tag = "reset";
        sbq.push_back(e);
        @(posedge clk); #1;
        reset = 1'b0;
        update_signal = 1'b0;
    endtask

    task automatic run_to(input int mode, input int rl, input int limit, input string tag);
        exp_t e;
        int n;
        n = 0;
        while (!(m_mode == mode && m_rl == rl) && n < limit) begin
            speed = 4'($urandom_range(1, 15));
            drive($urandom_range(0, 3) != 0, rnd_x(), rnd_y(), tag);
            n++;
        end
        e.due = cyc; e.is_mark = 1; e.reached = (m_mode == mode && m_rl == rl);
        e.rgb = 3'b000; e.onr = 1'b0; e.rl = 10'(rl); e.tag = tag;
        sbq.push_back(e);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            mon_e = sbq.pop_front();
            total++;
            if (mon_e.is_mark) begin
                if (!mon_e.reached) begin
                    bad++;
                    $display("FAIL %s: target road_left=%0d not reached within cycle budget",
                             mon_e.tag, mon_e.rl);
                end
            end else if (mon_e.due != cyc || rgb !== mon_e.rgb || on_road !== mon_e.onr
                         || road_left !== mon_e.rl) begin
                bad++;
                $display("FAIL %s cyc=%0d: got rgb=%b on_road=%b road_left=%0d, want rgb=%b on_road=%b road_left=%0d",
                         mon_e.tag, cyc, rgb, on_road, road_left, mon_e.rgb, mon_e.onr, mon_e.rl);
            end
        end
        if (end_req && sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected responses never compared", sbq.size());
            sbq.delete();
        end
    end

    initial begin
        reset = 1'b1; update_signal = 1'b0; alive = 1'b1; speed = 4'd0;
        pixel_x = '0; pixel_y = '0;
        model_reset();
        @(posedge clk); #1;

        // reset value, reset wins over a simultaneous tick
        do_reset(1'b1);
        drive(0, 150, 0, "terrain");
        drive(0, 192, 0, "edge_left");
        drive(0, 319, 0, "edge_right");
        drive(0, 320, 0, "past_road");

        // dash boundary after 3 ticks at 1 px/frame
        speed = 4'd4;
        repeat (3) drive(1, rnd_x(), rnd_y(), "scroll_tick");
        drive(0, 256, 45, "dash_on");
        drive(0, 256, 46, "dash_off");
        drive(0, 252, 46, "div_left_edge");
        drive(0, 260, 45, "div_right_out");

        // accumulator wrap at full speed
        do_reset(1'b0);
        speed = 4'd15;
        repeat (20) drive(1, rnd_x(), rnd_y(), "wrap_tick");
        drive(0, 256, 53, "wrap_dash_on");
        drive(0, 256, 54, "wrap_dash_off");
        repeat (20) drive(0, int'($urandom_range(250, 262)), rnd_y(), "wrap_phase");

        // frozen FSM at zero speed, then straight -> drift right -> hold at max
        do_reset(1'b0);
        speed = 4'd0;
        repeat (500) drive(1, rnd_x(), rnd_y(), "frozen");
        speed = 4'd4;
        repeat (248) drive(1, rnd_x(), rnd_y(), "drift_r");
        repeat (20) drive(1, rnd_x(), rnd_y(), "hold_max");

        // hold -> straight -> drift left down to the minimum clamp
        run_to(M_HOLD, 96, 3000, "reach_min");
        repeat (30) drive($urandom_range(0, 1) != 0, rnd_x(), rnd_y(), "hold_min");

        // reset in the middle of a left drift
        do_reset(1'b0);
        run_to(M_LEFT, 300, 3000, "reach_drift_l");
        do_reset(1'b0);
        speed = 4'd4;
        repeat (5) drive(1, rnd_x(), rnd_y(), "post_reset");

        // death flash on a terrain pixel
        do_reset(1'b0);
        alive = 1'b0;
        speed = 4'd0;
        repeat (8) drive(1, 50, 100, "flash_tick");
        drive(0, 50, 100, "flash_8");
        repeat (8) drive(1, 50, 100, "flash_tick");
        drive(0, 50, 100, "flash_16");
        repeat (8) drive(1, 50, 100, "flash_tick");
        drive(0, 50, 100, "flash_24");
        alive = 1'b1;
        drive(0, 50, 100, "alive_again");
        alive = 1'b0;
        drive(0, 50, 100, "phase_cleared");
        alive = 1'b1;

        // tick coinciding with a pixel uses pre-update scroll
        do_reset(1'b0);
        speed = 4'd4;
        repeat (63) drive(1, rnd_x(), rnd_y(), "pre_scroll");
        drive(1, 255, 42, "upd_pre");
        drive(0, 255, 42, "upd_post");

        // random mix of everything
        for (int i = 0; i < 400; i++) begin
            speed = 4'($urandom_range(0, 15));
            alive = ($urandom_range(0, 4) != 0);
            drive($urandom_range(0, 2) == 0, int'($urandom_range(0, 639)), rnd_y(), "random");
        end

        repeat (3) @(negedge clk);
        end_req = 1'b1;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
